cv32e40p_hamming_decoder: RTL and testbench
===========================================

CV32E40P_HAMMING_DECODER -- requirements
Module: cv32e40p_hamming_decoder

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of each saturating error counter.
REQ-002 Parameter CORRECT_EN, default 1; 1 = correct single-bit errors, 0 = detect and flag only.
REQ-003 Port clk  input  1  single clock, rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port valid_i  input  1  upstream codeword valid.
REQ-006 Port ready_o  output  1  decoder can accept a codeword.
REQ-007 Port code_i  input  38  received codeword: [31:0] data, [37:32] parity p1,p2,p4,p8,p16,p32.
REQ-008 Port valid_o  output  1  decoded result valid.
REQ-009 Port ready_i  input  1  downstream accepts result.
REQ-010 Port data_o  output  32  decoded, possibly corrected, data.
REQ-011 Port syndrome_o  output  6  syndrome of the beat on data_o.
REQ-012 Port corrected_o  output  1  beat had a correctable single-bit error.
REQ-013 Port uncorrectable_o  output  1  beat's syndrome maps to no code position.
REQ-014 Port clear_cnt_i  input  1  synchronous clear of both counters.
REQ-015 Port corr_cnt_o  output  CNT_WIDTH  count of corrected beats.
REQ-016 Port uncorr_cnt_o  output  CNT_WIDTH  count of uncorrectable beats.

Function
REQ-017 Code positions SHALL be numbered 1..38: parity pk at position k (1,2,4,8,16,32); data[i] at the i-th non-power-of-two position ascending (data[0]=3, data[3]=7, data[4]=9, data[10]=15, data[11]=17, data[25]=31, data[26]=33, data[31]=38).
REQ-018 Syndrome bit j SHALL equal received parity bit 32+j XOR the XOR of all data bits whose position has bit j set.
REQ-019 Syndrome 0 SHALL give corrected_o=0, uncorrectable_o=0, data_o=code_i[31:0].
REQ-020 Syndrome 1..38 SHALL set corrected_o=1; if it names a data position and CORRECT_EN=1, that data bit SHALL be inverted; a parity-position syndrome leaves data unchanged.
REQ-021 Syndrome 39..63 SHALL set uncorrectable_o=1, corrected_o=0, and pass data uncorrected.
REQ-022 Pipeline SHALL be two register stages (S1: code+syndrome, S2: corrected data+flags); latency exactly 2 cycles from accepted input to valid_o when unstalled.
REQ-023 Per-stage elastic handshake: s2_ready = !s2_valid | ready_i; s1_ready = !s1_valid | s2_ready; ready_o = s1_ready; transfer occurs only on valid&ready.
REQ-024 Throughput SHALL be one beat/cycle with ready_i held high; no beat SHALL be dropped or duplicated under arbitrary ready_i patterns.
REQ-025 While valid_o=1 and ready_i=0, data_o, syndrome_o and flags SHALL hold stable.
REQ-026 Counters SHALL increment on output handshake (valid_o&ready_i) of a flagged beat and saturate at all-ones.
REQ-027 clear_cnt_i SHALL win over a simultaneous increment (counter becomes 0).

Reset
REQ-028 rst_n low SHALL asynchronously clear both stage valids, valid_o, data_o, syndrome_o, corrected_o, uncorrectable_o, corr_cnt_o, uncorr_cnt_o to 0.
REQ-029 In-flight beats at reset SHALL be discarded; ready_o SHALL be 1 from the first cycle after release.

Structure
REQ-030 Package cv32e40p_hamming_pkg SHALL hold DATA_W=32, PARITY_W=6, CODE_W=38, MAX_POS=38 and the data-index-to-position table.
REQ-031 Syndrome computation SHALL live in combinational sub-module cv32e40p_hamming_syndrome (38-bit in, 6-bit out).

Verification
REQ-032 code_i=38'h0 -> after 2 cycles data_o=0, syndrome_o=0, no flags, counters unchanged.
REQ-033 Clean codeword of data 32'hDEADBEEF with code_i[0] flipped -> syndrome_o=3, corrected_o=1, data_o=32'hDEADBEEF, corr_cnt_o=1.
REQ-034 Zero codeword with code_i[32] flipped -> syndrome_o=1, corrected_o=1, data_o=0; with CORRECT_EN=0 and code_i[31] flipped -> syndrome_o=38, data_o=32'h80000000.
REQ-035 Zero codeword with code_i[31] and code_i[35] flipped -> syndrome_o=46, uncorrectable_o=1, data_o=32'h80000000, uncorr_cnt_o=1.
REQ-036 Stream 100 random beats with random ready_i -> output order and data match the model exactly; ready_o drops only when both stages are full and ready_i=0.
REQ-037 CNT_WIDTH=2, five corrected beats -> corr_cnt_o saturates at 3; clear_cnt_i asserted coincident with a sixth -> 0; rst_n pulsed mid-stream -> valid_o=0 immediately.

Source files
------------

// File: rtl/cv32e40p_hamming_pkg.sv
// Shared widths, the code-position map and the decoded-beat record for the
// (38,32) Hamming decoder.
package cv32e40p_hamming_pkg;

  localparam int DATA_W   = 32;
  localparam int PARITY_W = 6;
  localparam int CODE_W   = 38;
  localparam int MAX_POS  = 38;

  // Code position (1..38) of each data bit: the non-power-of-two positions in
  // ascending order.  Parity bit k sits at position 2**k and is not listed.
  localparam logic [PARITY_W-1:0] DATA_POS [DATA_W] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  // One decoded beat as it sits in the output stage.
  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [PARITY_W-1:0] syndrome;
    logic                corrected;
    logic                uncorrectable;
  } result_t;

  // A non-zero syndrome that lands on a real code position names a single bit.
  function automatic logic syn_in_range(input logic [PARITY_W-1:0] syn);
    return (syn != '0) && (syn <= PARITY_W'(MAX_POS));
  endfunction

endpackage

// File: rtl/cv32e40p_hamming_syndrome.sv
// Purely combinational syndrome generator: each syndrome bit re-checks one
// parity group against the received parity bit.
module cv32e40p_hamming_syndrome
  import cv32e40p_hamming_pkg::*;
(
  input  logic [CODE_W-1:0]   code,
  output logic [PARITY_W-1:0] syndrome
);

  // mask_bits[j][i] is data bit i when its position has bit j set.
  logic [PARITY_W-1:0][DATA_W-1:0] mask_bits;

  genvar gi, gj;
  generate
    for (gj = 0; gj < PARITY_W; gj++) begin : g_syn
      for (gi = 0; gi < DATA_W; gi++) begin : g_bit
        assign mask_bits[gj][gi] = code[gi] & DATA_POS[gi][gj];
      end
      assign syndrome[gj] = code[DATA_W+gj] ^ (^mask_bits[gj]);
    end
  endgenerate

endmodule

// File: rtl/cv32e40p_hamming_decoder.sv
// Two-stage elastic Hamming(38,32) decoder with single-error correction and
// saturating corrected/uncorrectable beat counters.
module cv32e40p_hamming_decoder
  import cv32e40p_hamming_pkg::*;
#(
  parameter int          CNT_WIDTH  = 16,
  parameter int unsigned CORRECT_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [CODE_W-1:0]    code_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DATA_W-1:0]    data_o,
  output logic [PARITY_W-1:0]  syndrome_o,
  output logic                 corrected_o,
  output logic                 uncorrectable_o,
  input  logic                 clear_cnt_i,
  output logic [CNT_WIDTH-1:0] corr_cnt_o,
  output logic [CNT_WIDTH-1:0] uncorr_cnt_o
);

  logic                s1_valid_reg;
  logic [DATA_W-1:0]   s1_data_reg;
  logic [PARITY_W-1:0] s1_syn_reg;
  logic                s2_valid_reg;
  result_t             s2_result_reg;

  logic                s1_ready;
  logic                s2_ready;
  logic [PARITY_W-1:0] syn_next;
  logic [DATA_W-1:0]   flip_mask;
  result_t             result_next;

  // Each stage may load when it is empty or its contents move on this cycle.
  assign s2_ready = !s2_valid_reg || ready_i;
  assign s1_ready = !s1_valid_reg || s2_ready;
  assign ready_o  = s1_ready;

  cv32e40p_hamming_syndrome u_syndrome (
    .code     (code_i),
    .syndrome (syn_next)
  );

  // Stage 1 captures the data bits together with their syndrome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_syn_reg   <= '0;
    end else if (s1_ready) begin
      s1_valid_reg <= valid_i;
      if (valid_i) begin
        s1_data_reg <= code_i[DATA_W-1:0];
        s1_syn_reg  <= syn_next;
      end
    end
  end

  // A syndrome equal to a data position selects exactly that bit; parity
  // positions and out-of-range syndromes match no entry and flip nothing.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_flip
      assign flip_mask[gi] = (CORRECT_EN != 0) && (s1_syn_reg == DATA_POS[gi]);
    end
  endgenerate

  // Classify the stage-1 syndrome and build the corrected beat.
  always_comb begin
    result_next               = '0;
    result_next.syndrome      = s1_syn_reg;
    result_next.corrected     = syn_in_range(s1_syn_reg);
    result_next.uncorrectable = s1_syn_reg > PARITY_W'(MAX_POS);
    result_next.data          = s1_data_reg ^ flip_mask;
  end

  // Stage 2 holds the decoded beat; it only changes when it can be replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= '0;
    end else if (s2_ready) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_result_reg <= result_next;
      end
    end
  end

  assign valid_o         = s2_valid_reg;
  assign data_o          = s2_result_reg.data;
  assign syndrome_o      = s2_result_reg.syndrome;
  assign corrected_o     = s2_result_reg.corrected;
  assign uncorrectable_o = s2_result_reg.uncorrectable;

  // Counter 0 tracks corrected beats, counter 1 uncorrectable beats; both
  // count only beats actually taken downstream.
  logic [1:0]                    cnt_hit;
  logic [1:0][CNT_WIDTH-1:0]     cnt_all;

  assign cnt_hit[0] = s2_valid_reg && ready_i && s2_result_reg.corrected;
  assign cnt_hit[1] = s2_valid_reg && ready_i && s2_result_reg.uncorrectable;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;

      // Saturating counter; a clear request overrides a coincident increment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (clear_cnt_i) begin
          cnt_reg <= '0;
        end else if (cnt_hit[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
      end

      assign cnt_all[gi] = cnt_reg;
    end
  endgenerate

  assign corr_cnt_o   = cnt_all[0];
  assign uncorr_cnt_o = cnt_all[1];

endmodule

// File: tb/tb_cv32e40p_hamming_decoder.sv
// Self-checking bench: directed corner beats, saturation on a narrow-counter
// detect-only instance, a random elastic stream and a mid-stream reset.
module tb_cv32e40p_hamming_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance (CNT_WIDTH=16, correction on)
  logic        valid_i = 1'b0, ready_i = 1'b0, clear_cnt_i = 1'b0;
  logic [37:0] code_i = '0;
  logic        ready_o, valid_o, corrected_o, uncorrectable_o;
  logic [31:0] data_o;
  logic [5:0]  syndrome_o;
  logic [15:0] corr_cnt_o, uncorr_cnt_o;

  // Narrow, detect-only instance
  logic        a_valid_i = 1'b0, a_ready_i = 1'b0, a_clear_cnt_i = 1'b0;
  logic [37:0] a_code_i = '0;
  logic        a_ready_o, a_valid_o, a_corrected_o, a_uncorrectable_o;
  logic [31:0] a_data_o;
  logic [5:0]  a_syndrome_o;
  logic [1:0]  a_corr_cnt_o, a_uncorr_cnt_o;

  cv32e40p_hamming_decoder u_dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .code_i(code_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .syndrome_o(syndrome_o), .corrected_o(corrected_o),
    .uncorrectable_o(uncorrectable_o), .clear_cnt_i(clear_cnt_i),
    .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o)
  );

  cv32e40p_hamming_decoder #(.CNT_WIDTH(2), .CORRECT_EN(0)) u_alt (
    .clk(clk), .rst_n(rst_n), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .code_i(a_code_i), .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o),
    .syndrome_o(a_syndrome_o), .corrected_o(a_corrected_o),
    .uncorrectable_o(a_uncorrectable_o), .clear_cnt_i(a_clear_cnt_i),
    .corr_cnt_o(a_corr_cnt_o), .uncorr_cnt_o(a_uncorr_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (position arithmetic) ----------------
  // Position of data bit i: the i-th integer >= 1 that is not a power of two.
  function automatic int pos_of(input int i);
    int p = 0;
    int n = -1;
    while (n < i) begin
      p++;
      if ((p & (p - 1)) != 0) n++;
    end
    return p;
  endfunction

  // Syndrome = XOR of the positions of every set bit in the codeword.
  function automatic logic [5:0] model_syn(input logic [37:0] c);
    int s = 0;
    for (int i = 0; i < 32; i++) if (c[i]) s ^= pos_of(i);
    for (int j = 0; j < 6; j++) if (c[32+j]) s ^= (1 << j);
    return 6'(s);
  endfunction

  function automatic logic [37:0] encode(input logic [31:0] d);
    int s = 0;
    for (int i = 0; i < 32; i++) if (d[i]) s ^= pos_of(i);
    return {6'(s), d};
  endfunction

  function automatic logic [31:0] model_data(input logic [37:0] c, input bit correct);
    int          s = int'(model_syn(c));
    logic [31:0] d = c[31:0];
    if (correct && s >= 1 && s <= 38)
      for (int i = 0; i < 32; i++) if (pos_of(i) == s) d[i] = ~d[i];
    return d;
  endfunction

  task automatic main_beat(input logic [37:0] c);
    valid_i = 1'b1; code_i = c; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("lat1_valid_o", 64'(valid_o), 64'(1'b0));
    @(posedge clk); #1;
  endtask

  task automatic alt_beat(input logic [37:0] c);
    a_valid_i = 1'b1; a_code_i = c; a_ready_i = 1'b1;
    @(posedge clk); #1;
    a_valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [37:0] c, ec;
    logic [31:0] d;
    logic [5:0]  es, prev_syn;
    logic [31:0] prev_data;
    logic        prev_stall, prev_corr, prev_unc;
    int          sent, rcvd, cyc, exp_corr, exp_unc, nflip;
    logic [37:0] q[$];

    // ---- reset ----
    @(posedge clk); #1;
    check("rst_valid_o", 64'(valid_o), 64'(1'b0));
    check("rst_data_o", 64'(data_o), 64'(0));
    check("rst_syndrome_o", 64'(syndrome_o), 64'(0));
    check("rst_flags", 64'({corrected_o, uncorrectable_o}), 64'(0));
    check("rst_counters", 64'({corr_cnt_o, uncorr_cnt_o}), 64'(0));
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", 64'(ready_o), 64'(1'b1));

    // ---- directed beats ----
    main_beat(38'h0);
    check("zero_valid_o", 64'(valid_o), 64'(1'b1));
    check("zero_data_o", 64'(data_o), 64'(0));
    check("zero_syndrome", 64'(syndrome_o), 64'(0));
    check("zero_flags", 64'({corrected_o, uncorrectable_o}), 64'(0));
    @(posedge clk); #1;
    check("zero_counters", 64'({corr_cnt_o, uncorr_cnt_o}), 64'(0));

    c = encode(32'hDEADBEEF) ^ 38'h1;
    main_beat(c);
    check("dbe_syndrome", 64'(syndrome_o), 64'(3));
    check("dbe_corrected", 64'(corrected_o), 64'(1'b1));
    check("dbe_uncorr", 64'(uncorrectable_o), 64'(1'b0));
    check("dbe_data_o", 64'(data_o), 64'(32'hDEADBEEF));
    @(posedge clk); #1;
    check("dbe_corr_cnt", 64'(corr_cnt_o), 64'(1));

    main_beat(38'h1 << 32);
    check("p1_syndrome", 64'(syndrome_o), 64'(1));
    check("p1_corrected", 64'(corrected_o), 64'(1'b1));
    check("p1_data_o", 64'(data_o), 64'(0));
    @(posedge clk); #1;
    check("p1_corr_cnt", 64'(corr_cnt_o), 64'(2));

    main_beat((38'h1 << 31) | (38'h1 << 35));
    check("dbl_syndrome", 64'(syndrome_o), 64'(46));
    check("dbl_uncorr", 64'(uncorrectable_o), 64'(1'b1));
    check("dbl_corrected", 64'(corrected_o), 64'(1'b0));
    check("dbl_data_o", 64'(data_o), 64'(32'h80000000));
    @(posedge clk); #1;
    check("dbl_uncorr_cnt", 64'(uncorr_cnt_o), 64'(1));
    check("dbl_corr_cnt", 64'(corr_cnt_o), 64'(2));

    // ---- detect-only, 2-bit counters ----
    alt_beat(38'h1 << 31);
    check("alt_syndrome", 64'(a_syndrome_o), 64'(38));
    check("alt_data_o", 64'(a_data_o), 64'(32'h80000000));
    check("alt_corrected", 64'(a_corrected_o), 64'(1'b1));
    @(posedge clk); #1;
    check("alt_cnt_1", 64'(a_corr_cnt_o), 64'(1));
    for (int k = 0; k < 4; k++) begin
      alt_beat(encode($urandom()) ^ (38'h1 << $urandom_range(37)));
      @(posedge clk); #1;
    end
    check("alt_cnt_sat", 64'(a_corr_cnt_o), 64'(3));
    check("alt_uncorr_cnt", 64'(a_uncorr_cnt_o), 64'(0));
    a_valid_i = 1'b1; a_code_i = 38'h1 << 5; a_ready_i = 1'b1;
    @(posedge clk); #1;
    a_valid_i = 1'b0;
    @(posedge clk); #1;
    check("alt_sixth_valid", 64'(a_valid_o), 64'(1'b1));
    a_clear_cnt_i = 1'b1;
    @(posedge clk); #1;
    a_clear_cnt_i = 1'b0;
    check("alt_clear_wins", 64'(a_corr_cnt_o), 64'(0));

    // ---- random elastic stream ----
    clear_cnt_i = 1'b1;
    @(posedge clk); #1;
    clear_cnt_i = 1'b0;
    check("clear_counters", 64'({corr_cnt_o, uncorr_cnt_o}), 64'(0));
    sent = 0; rcvd = 0; cyc = 0; exp_corr = 0; exp_unc = 0;
    prev_stall = 1'b0; prev_data = '0; prev_syn = '0; prev_corr = 1'b0; prev_unc = 1'b0;
    while ((sent < 100 || rcvd < 100) && cyc < 4000) begin
      if (prev_stall) begin
        check("hold_valid_o", 64'(valid_o), 64'(1'b1));
        check("hold_data_o", 64'(data_o), 64'(prev_data));
        check("hold_syndrome", 64'(syndrome_o), 64'(prev_syn));
        check("hold_flags", 64'({corrected_o, uncorrectable_o}), 64'({prev_corr, prev_unc}));
      end
      valid_i = (sent < 100) && ($urandom_range(3) != 0);
      d = $urandom();
      c = encode(d);
      nflip = int'($urandom_range(2));
      for (int k = 0; k < nflip; k++) c[$urandom_range(37)] ^= 1'b1;
      code_i  = c;
      ready_i = $urandom_range(1) != 0;
      #1;
      check("stream_ready_o", 64'(ready_o), 64'(!(q.size() == 2 && !ready_i)));
      if (valid_o && ready_i) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL stream_extra_beat observed=data %0h expected=no beat", data_o);
        end
        if (q.size() != 0) begin
          ec = q.pop_front();
          es = model_syn(ec);
          check("stream_data_o", 64'(data_o), 64'(model_data(ec, 1'b1)));
          check("stream_syndrome", 64'(syndrome_o), 64'(es));
          check("stream_corrected", 64'(corrected_o), 64'(es >= 1 && es <= 38));
          check("stream_uncorr", 64'(uncorrectable_o), 64'(es > 38));
          if (es >= 1 && es <= 38) exp_corr++;
          if (es > 38) exp_unc++;
          rcvd++;
        end
      end
      if (valid_i && ready_o) begin
        q.push_back(c);
        sent++;
      end
      prev_stall = valid_o && !ready_i;
      prev_data = data_o; prev_syn = syndrome_o;
      prev_corr = corrected_o; prev_unc = uncorrectable_o;
      @(posedge clk); #1;
      cyc++;
    end
    valid_i = 1'b0;
    check("stream_received", 64'(rcvd), 64'(100));
    check("stream_corr_cnt", 64'(corr_cnt_o), 64'(exp_corr));
    check("stream_uncorr_cnt", 64'(uncorr_cnt_o), 64'(exp_unc));

    // ---- reset mid-stream ----
    ready_i = 1'b0; valid_i = 1'b1; code_i = encode($urandom()) ^ 38'h2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("pre_rst_valid_o", 64'(valid_o), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid_o", 64'(valid_o), 64'(1'b0));
    check("async_rst_data_o", 64'(data_o), 64'(0));
    check("async_rst_syndrome", 64'(syndrome_o), 64'(0));
    check("async_rst_flags", 64'({corrected_o, uncorrectable_o}), 64'(0));
    check("async_rst_counters", 64'({corr_cnt_o, uncorr_cnt_o}), 64'(0));
    #2;
    rst_n = 1'b1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready_o", 64'(ready_o), 64'(1'b1));
    check("post_rst_valid_o", 64'(valid_o), 64'(1'b0));
    @(posedge clk); #1;
    check("inflight_discarded", 64'(valid_o), 64'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
